// File: rtl/fir_pkg.sv
// Shared definitions for the FIR block and its configuration master:
// sequencer state encoding and AXI-Lite register map.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_LEN,
    WR_TAP,
    RD_TAP,
    WR_START,
    POLL,
    DONE
  } fir_state_t;

  localparam int unsigned REG_CTRL  = 32'h00;
  localparam int unsigned REG_LEN   = 32'h10;
  localparam int unsigned REG_TAP   = 32'h20;

  localparam int unsigned CTRL_AP_START = 32'h1;
  localparam int          CTRL_DONE_BIT = 1;

  // Byte offset of coefficient k in the tap window.
  function automatic int unsigned tap_offset(input int unsigned k);
    return REG_TAP + (k << 2);
  endfunction

endpackage

// File: rtl/fir_cfg_master_if.sv
// AXI-Lite write-address, write-data, read-address and read-data channels
// (no B channel) between the configuration master and the FIR.
interface fir_cfg_master_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);

  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );

endinterface

// File: rtl/axil_wr_chan.sv
// AXI-Lite write issue: raises aw/w together on req, retires each handshake
// independently and flags completion once both have happened.
module axil_wr_chan #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   req,
  input  logic [pADDR_WIDTH-1:0] req_addr,
  input  logic [pDATA_WIDTH-1:0] req_data,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wr_done
);

  logic aw_seen;
  logic w_seen;
  logic aw_hs;
  logic w_hs;

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  // Complete when both channels have handshaken, in either order or together.
  assign wr_done = (aw_seen | aw_hs) & (w_seen | w_hs);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
    end else if (req) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      awaddr  <= req_addr;
      wdata   <= req_data;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
    end else begin
      if (aw_hs) awvalid <= 1'b0;
      if (w_hs)  wvalid  <= 1'b0;
      if (wr_done) begin
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end else begin
        if (aw_hs) aw_seen <= 1'b1;
        if (w_hs)  w_seen  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_cfg_master.sv
// FIR configuration sequencer: writes length and taps, reads taps back,
// starts the FIR and polls for completion over AXI-Lite.
module fir_cfg_master
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [pDATA_WIDTH-1:0] data_length,
  output logic [3:0]             tap_idx,
  input  logic [pDATA_WIDTH-1:0] tap_coef,
  fir_cfg_master_if.master       bus,
  output logic                   busy,
  output logic                   done,
  output logic                   coef_err
);

  localparam logic [3:0] LAST_TAP = 4'(Tape_Num - 1);

  fir_state_t             state;
  fir_state_t             state_n;
  logic [3:0]             k;
  logic                   issued;
  logic                   wr_req;
  logic                   rd_req;
  logic [pADDR_WIDTH-1:0] wr_addr;
  logic [pDATA_WIDTH-1:0] wr_data;
  logic [pADDR_WIDTH-1:0] rd_addr;
  logic [pADDR_WIDTH-1:0] tap_addr;
  logic                   wr_done;
  logic                   rd_done;
  logic                   last_tap;

  assign tap_idx  = k;
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);
  assign last_tap = (k == LAST_TAP);
  assign tap_addr = pADDR_WIDTH'(tap_offset(32'(k)));
  // Data is only accepted once the address phase has retired.
  assign rd_done  = bus.rready & bus.rvalid & ~bus.arvalid;

  axil_wr_chan #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_wr_chan (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .req        (wr_req),
    .req_addr   (wr_addr),
    .req_data   (wr_data),
    .awvalid    (bus.awvalid),
    .awready    (bus.awready),
    .awaddr     (bus.awaddr),
    .wvalid     (bus.wvalid),
    .wready     (bus.wready),
    .wdata      (bus.wdata),
    .wr_done    (wr_done)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= IDLE;
    else             state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no branch
  // can leave a value held and infer a latch.
  always_comb begin
    state_n = state;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    case (state)
      IDLE: if (start) state_n = WR_LEN;
      WR_LEN: begin
        wr_addr = pADDR_WIDTH'(REG_LEN);
        wr_data = data_length;
        wr_req  = !issued;
        if (wr_done) state_n = WR_TAP;
      end
      WR_TAP: begin
        wr_addr = tap_addr;
        wr_data = tap_coef;
        wr_req  = !issued;
        if (wr_done && last_tap) state_n = RD_TAP;
      end
      RD_TAP: begin
        rd_addr = tap_addr;
        rd_req  = !issued;
        if (rd_done && last_tap) state_n = WR_START;
      end
      WR_START: begin
        wr_addr = pADDR_WIDTH'(REG_CTRL);
        wr_data = pDATA_WIDTH'(CTRL_AP_START);
        wr_req  = !issued;
        if (wr_done) state_n = POLL;
      end
      POLL: begin
        rd_addr = pADDR_WIDTH'(REG_CTRL);
        rd_req  = !issued;
        if (rd_done && bus.rdata[CTRL_DONE_BIT]) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read channel, transaction bookkeeping, tap counter and error flag.
  // issued clears on completion, giving one idle cycle before the next request.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      bus.arvalid <= 1'b0;
      bus.araddr  <= '0;
      bus.rready  <= 1'b0;
      issued      <= 1'b0;
      k           <= '0;
      coef_err    <= 1'b0;
    end else begin
      if (rd_req) begin
        bus.arvalid <= 1'b1;
        bus.araddr  <= rd_addr;
        bus.rready  <= 1'b1;
      end else begin
        if (bus.arvalid && bus.arready) bus.arvalid <= 1'b0;
        if (rd_done)                    bus.rready  <= 1'b0;
      end

      if (wr_req || rd_req)        issued <= 1'b1;
      else if (wr_done || rd_done) issued <= 1'b0;

      if (state == IDLE && start) begin
        k        <= '0;
        coef_err <= 1'b0;
      end else begin
        if ((state == WR_TAP && wr_done) || (state == RD_TAP && rd_done))
          k <= last_tap ? 4'd0 : k + 4'd1;
        if (state == RD_TAP && rd_done && bus.rdata != tap_coef)
          coef_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fir_cfg_master.md
FIR_CFG_MASTER -- requirements
Module: fir_cfg_master

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  pADDR_WIDTH  12  AXI-Lite address width
  pDATA_WIDTH  32  AXI-Lite data width
  Tape_Num     11  number of FIR taps
REQ-002 Ports (name, direction, width, meaning), one per line:
  axis_clk     in   1   single clock; all logic on its rising edge
  axis_rst_n   in   1   reset, asynchronous assert, active-low
  start        in   1   begin programming sequence
  data_length  in   32  value written to 0x10
  tap_idx      out  4   index of coefficient requested
  tap_coef     in   32  signed coefficient for tap_idx, combinational source
  awvalid/awready  out/in  1   write-address handshake
  awaddr       out  12  write address
  wvalid/wready    out/in  1   write-data handshake
  wdata        out  32  write data
  arvalid/arready  out/in  1   read-address handshake
  araddr       out  12  read address
  rvalid/rready    in/out  1   read-data handshake
  rdata        in   32  read data
  busy         out  1   sequence in progress
  done         out  1   one-cycle completion pulse
  coef_err     out  1   sticky readback-mismatch flag

Function
REQ-003 FSM states SHALL be IDLE, WR_LEN, WR_TAP, RD_TAP, WR_START, POLL and DONE.
REQ-004 In IDLE, start=1 at a clock edge SHALL enter WR_LEN, set busy, clear coef_err and clear tap counter k.
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 Each write SHALL assert awvalid and wvalid together, holding awaddr and wdata stable until each handshake completes.
REQ-007 awvalid SHALL drop the cycle after awvalid&awready, and wvalid SHALL drop the cycle after wvalid&wready, independently of each other.
REQ-008 A write SHALL be complete once both handshakes have occurred, in either order or the same cycle; the next state follows on the next edge; no B channel exists.
REQ-009 WR_LEN SHALL write data_length to 0x10.
REQ-010 WR_TAP SHALL write tap_coef to 0x20+4k with tap_idx=k, for k=0..Tape_Num-1 in order, then enter RD_TAP with k=0.
REQ-011 RD_TAP SHALL assert arvalid with araddr=0x20+4k, drop it the cycle after arready, and hold rready=1 until rvalid.
REQ-012 On rvalid&rready in RD_TAP, the block SHALL compare rdata to tap_coef (tap_idx=k) over all 32 bits; a mismatch sets coef_err.
REQ-013 The sequence SHALL continue after a mismatch; after tap Tape_Num-1 it SHALL enter WR_START.
REQ-014 WR_START SHALL write 0x0000_0001 to 0x00.
REQ-015 POLL SHALL read 0x00 repeatedly with exactly one idle cycle between a read completing and the next arvalid.
REQ-016 In POLL, rdata[1]=1 SHALL enter DONE; otherwise polling SHALL continue without limit.
REQ-017 DONE SHALL assert done for exactly one cycle, deassert busy and return to IDLE; coef_err SHALL hold until the next accepted start.
REQ-018 rready SHALL be 1 only while a read is outstanding; rvalid with no outstanding read, and awready/wready/arready while the matching valid is low, SHALL be ignored.
REQ-019 At most one AXI-Lite transaction SHALL be outstanding at any time, and reads and writes SHALL never overlap.

Reset
REQ-020 axis_rst_n=0 SHALL asynchronously force IDLE, k=0, and all outputs to 0 (valids, rready, addresses, wdata, tap_idx, busy, done, coef_err), including in the middle of a transaction.

Structure
REQ-021 The FSM state encoding and the register offsets 0x00, 0x10 and 0x20 SHALL reside in a shared package fir_pkg, also used by fir.
REQ-022 One sub-module, axil_wr_chan, SHALL implement the independent aw/w handshake tracking; everything else stays in fir_cfg_master.

Verification
REQ-023 Reset, then no start -> all outputs 0 and no valid asserted for 20 cycles.
REQ-024 Zero-wait responder, data_length=600, coefficients {0,-10,-9,23,56,63,56,23,-9,-10,0}, poll returns 0x4 twice then 0x6 -> writes 0x10=600, 0x20..0x48 in order, 11 readbacks, 0x00=1, three polls, one done pulse, coef_err=0.
REQ-025 Responder asserts wready 3 cycles before awready on every write -> exactly one accepted write per address, wdata stable throughout.
REQ-026 Readback of tap 5 returns 62 -> coef_err=1 at done, and WR_START plus POLL still occur.
REQ-027 start pulsed during WR_TAP -> ignored, with exactly one done pulse.
REQ-028 axis_rst_n low mid-RD_TAP with arvalid high -> arvalid and rready go 0 immediately, and a later start runs the full sequence cleanly.
